// File: rtl/ones4_ctrl.sv
// ones4_ctrl: Moore controller sequencing the load/clear/scan of the ones-count datapath.
module ones4_ctrl #(
  parameter int WIDTH = 8,
  localparam int ITW = $clog2(WIDTH + 1)
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Start,
  input  logic Nd0,
  input  logic N0d0,
  output logic MuxN,
  output logic LoadN,
  output logic MuxC,
  output logic LoadC,
  output logic Out,
  output logic Busy,
  output logic Done
);
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_TEST, S_INC, S_SHIFT, S_OUT} state_t;
  state_t state, nxt;
  logic [ITW-1:0] it;
  logic [6:0] outs, dec;
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE:  nxt = Start ? S_INIT : S_IDLE;
      S_INIT:  nxt = S_TEST;
      S_TEST:  nxt = Nd0 ? S_OUT : N0d0 ? S_INC : S_SHIFT;
      S_INC:   nxt = S_SHIFT;
      S_SHIFT: nxt = (it == ITW'(WIDTH - 1)) ? S_OUT : S_TEST;
      S_OUT:   nxt = Start ? S_OUT : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  // {MuxN, LoadN, MuxC, LoadC, Out, Busy, Done}, decoded from the next state so the
  // registered copy always matches the state register.
  always_comb begin
    dec = '0;
    case (nxt)
      S_INIT:  dec = 7'b1111010;
      S_TEST:  dec = 7'b0000010;
      S_INC:   dec = 7'b0001010;
      S_SHIFT: dec = 7'b0100010;
      S_OUT:   dec = 7'b0000101;
      default: dec = '0;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
      it    <= '0;
      outs  <= '0;
    end else begin
      state <= nxt;
      outs  <= dec;
      if (state == S_INIT) it <= '0;
      else if (state == S_SHIFT) it <= it + 1'b1;
    end
  end
  assign {MuxN, LoadN, MuxC, LoadC, Out, Busy, Done} = outs;
endmodule

// File: tb/tb_ones4_ctrl.sv
// tb_ones4_ctrl: randomized bench with a behavioural datapath and a cycle/popcount reference.
module tb_ones4_ctrl;
  logic clk = 0, rst = 1, start = 0;
  logic nd0, n0d0, mux_n, load_n, mux_c, load_c, out, busy, done;
  logic [7:0] n_in = 0, n_reg, c_reg;
  wire data;
  int checks = 0, errors = 0;

  ones4_ctrl dut (
    .Clock(clk), .Reset(rst), .Start(start), .Nd0(nd0), .N0d0(n0d0),
    .MuxN(mux_n), .LoadN(load_n), .MuxC(mux_c), .LoadC(load_c),
    .Out(out), .Busy(busy), .Done(done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg <= '0;
      c_reg <= '0;
    end else begin
      if (load_n) n_reg <= mux_n ? n_in : n_reg >> 1;
      if (load_c) c_reg <= mux_c ? 8'd0 : c_reg + 8'd1;
    end
  end
  assign nd0  = (n_reg == 0);
  assign n0d0 = n_reg[0];
  assign data = out ? (c_reg == 8'd4) : 1'bz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] outs();
    return {mux_n, load_n, mux_c, load_c, out, busy, done};
  endfunction

  // Cycles from the sampling edge to the first Done cycle: 2 to reach the first test,
  // then 2 per zero bit and 3 per one bit scanned, plus a final test unless the cap hit.
  function automatic int ref_lat(input logic [7:0] v);
    logic [7:0] r = v;
    int l = 2;
    for (int i = 0; i < 8; i++) begin
      if (r == 0) return l + 1;
      l += 2 + int'(r[0]);
      r = r >> 1;
    end
    return l;
  endfunction

  function automatic int popcnt(input logic [7:0] v);
    int p = 0;
    for (int i = 0; i < 8; i++) p += int'(v[i]);
    return p;
  endfunction

  task automatic run_scan(input logic [7:0] v, input bit rnd, input int hold);
    int lat = -1;
    n_in  = v;
    start = 1;
    tick();
    check($sformatf("init_outs_%h", v), outs(), 7'b1111010);
    for (int k = 2; k <= 40; k++) begin
      start = rnd ? 1'($urandom) : 1'b0;
      tick();
      if (done) begin
        lat = k;
        break;
      end
      check($sformatf("busy_%h_%0d", v, k), {busy, out}, 2'b10);
    end
    check($sformatf("latency_%h", v), lat, ref_lat(v));
    check($sformatf("count_%h", v), c_reg, popcnt(v));
    check($sformatf("data_%h", v), data, popcnt(v) == 4);
    check($sformatf("out_%h", v), outs(), 7'b0000101);
    for (int h = 0; h < hold; h++) begin
      start = 1;
      tick();
      check($sformatf("hold_done_%h", v), outs(), 7'b0000101);
    end
    start = 0;
    tick();
    check($sformatf("idle_outs_%h", v), outs(), 7'b0);
    check($sformatf("idle_data_%h", v), data, 1'bz);
  endtask

  initial begin
    tick();
    tick();
    check("reset_outs", outs(), 7'b0);
    rst = 0;
    tick();
    check("idle_no_start", outs(), 7'b0);

    // Reset mid-scan while in the increment state.
    n_in  = 8'h01;
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    check("inc_outs", outs(), 7'b0001010);
    rst = 1;
    tick();
    tick();
    rst = 0;
    check("rst_outs", outs(), 7'b0);
    check("rst_c", c_reg, 0);
    check("rst_n", n_reg, 0);
    tick();
    check("rst_stay_idle", outs(), 7'b0);

    run_scan(8'h00, 0, 0);
    run_scan(8'h0F, 0, 3);
    run_scan(8'hFF, 0, 0);
    run_scan(8'h01, 0, 0);
    run_scan(8'h80, 1, 2);
    run_scan(8'hF0, 1, 0);

    // Start held through S_OUT, then released and raised again restarts.
    run_scan(8'h3C, 1, 4);
    start = 1;
    tick();
    check("restart_init", outs(), 7'b1111010);
    start = 0;
    rst = 1;
    tick();
    rst = 0;
    check("restart_reset", outs(), 7'b0);

    for (int i = 0; i < 30; i++) run_scan(8'($urandom), 1, int'($urandom_range(0, 2)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
